// File: rtl/i2s_tx_param.sv
// Parametrised I2S / left-justified stereo transmitter: one-deep sample-pair buffer,
// SCLK/LRCLK generated from MCLK, each channel shifted out MSB-first in its slot.
module i2s_tx_param #(
  parameter int DATA_W        = 16,
  parameter int SLOT_W        = 32,
  parameter int SCLK_DIV      = 4,
  parameter int MODE          = 0,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sclk_o,
  output logic              lrclk_o,
  output logic              sdata_o,
  output logic              mclk_o,
  output logic              underrun_o
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int POS_W = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT_W - 1);
  localparam logic [POS_W-1:0] SLOT_LEN = POS_W'(SLOT_W);
  localparam logic             LR_RST   = (MODE == 1) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic              div_wrap, fall_tick, sclk_nxt;
  logic [POS_W-1:0]  pos, pos_nxt, lr_pos, slot_bit;
  logic              frame_start, write;
  logic              full, full_nxt;
  logic [DATA_W-1:0] hold_left, hold_right;
  logic [DATA_W-1:0] left_sh, right_sh, left_nxt, right_nxt;
  logic [DATA_W-1:0] sample, sample_shl;
  logic              lrclk_nxt, sdata_nxt, underrun_nxt;

  assign s_ready = !full;
  assign mclk_o  = mclk;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    div_wrap     = (div_cnt == DIV_LAST);
    div_cnt_nxt  = div_wrap ? '0 : div_cnt + 1'b1;
    sclk_nxt     = sclk_o ^ div_wrap;
    fall_tick    = div_wrap && sclk_o;
    pos_nxt      = (pos == POS_LAST) ? '0 : pos + 1'b1;
    frame_start  = fall_tick && (pos_nxt == '0);
    write        = s_valid && !full;

    left_nxt     = left_sh;
    right_nxt    = right_sh;
    full_nxt     = full;
    underrun_nxt = 1'b0;

    // A write can only happen while empty and a load only clears when full, so they never collide.
    if (write) full_nxt = 1'b1;
    if (frame_start) begin
      if (full) begin
        left_nxt  = hold_left;
        right_nxt = hold_right;
        full_nxt  = 1'b0;
      end else begin
        underrun_nxt = 1'b1;
        if (UNDERRUN_ZERO != 0) begin
          left_nxt  = '0;
          right_nxt = '0;
        end
      end
    end

    // Bits past DATA_W shift out of the top, giving the zero padding for free.
    slot_bit   = (pos_nxt >= SLOT_LEN) ? pos_nxt - SLOT_LEN : pos_nxt;
    sample     = (pos_nxt >= SLOT_LEN) ? right_nxt : left_nxt;
    sample_shl = sample << slot_bit;
    sdata_nxt  = sample_shl[DATA_W-1];

    lr_pos    = (pos_nxt == POS_LAST) ? '0 : pos_nxt + 1'b1;
    lrclk_nxt = (MODE == 1) ? (pos_nxt >= SLOT_LEN) : (lr_pos >= SLOT_LEN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      sclk_o     <= 1'b0;
      pos        <= POS_LAST;
      lrclk_o    <= LR_RST;
      sdata_o    <= 1'b0;
      full       <= 1'b0;
      left_sh    <= '0;
      right_sh   <= '0;
      underrun_o <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_nxt;
      sclk_o     <= sclk_nxt;
      full       <= full_nxt;
      underrun_o <= underrun_nxt;
      if (fall_tick) begin
        pos      <= pos_nxt;
        lrclk_o  <= lrclk_nxt;
        sdata_o  <= sdata_nxt;
        left_sh  <= left_nxt;
        right_sh <= right_nxt;
      end
    end
  end

  // NOTE: the holding registers carry no reset; 'full' alone says whether they hold a valid pair.
  always_ff @(posedge mclk) begin
    if (write) begin
      hold_left  <= s_left;
      hold_right <= s_right;
    end
  end

endmodule

// File: tb/tb_i2s_tx_param.sv
// Directed bench for i2s_tx_param: default, left-justified, zero-on-underrun and SCLK_DIV=1 instances
// driven in lockstep; serial frames are collected on SCLK fall ticks and compared with hand values.
module tb_i2s_tx_param;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        rst_n, s_valid, s_valid3;
  logic [15:0] s_left, s_right;
  logic [7:0]  l3, r3;
  logic rdy0, sclk0, lr0, sd0, mo0, ur0;
  logic rdy1, sclk1, lr1, sd1, mo1, ur1;
  logic rdy2, sclk2, lr2, sd2, mo2, ur2;
  logic rdy3, sclk3, lr3, sd3, mo3, ur3;

  i2s_tx_param dut0 (
    .mclk(mclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy0), .s_left(s_left), .s_right(s_right),
    .sclk_o(sclk0), .lrclk_o(lr0), .sdata_o(sd0), .mclk_o(mo0), .underrun_o(ur0));

  i2s_tx_param #(.MODE(1)) dut1 (
    .mclk(mclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy1), .s_left(s_left), .s_right(s_right),
    .sclk_o(sclk1), .lrclk_o(lr1), .sdata_o(sd1), .mclk_o(mo1), .underrun_o(ur1));

  i2s_tx_param #(.UNDERRUN_ZERO(1)) dut2 (
    .mclk(mclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy2), .s_left(s_left), .s_right(s_right),
    .sclk_o(sclk2), .lrclk_o(lr2), .sdata_o(sd2), .mclk_o(mo2), .underrun_o(ur2));

  i2s_tx_param #(.DATA_W(8), .SLOT_W(16), .SCLK_DIV(1)) dut3 (
    .mclk(mclk), .rst_n(rst_n), .s_valid(s_valid3), .s_ready(rdy3), .s_left(l3), .s_right(r3),
    .sclk_o(sclk3), .lrclk_o(lr3), .sdata_o(sd3), .mclk_o(mo3), .underrun_o(ur3));

  int vectors = 0;
  int miscompares = 0;

  int cyc, fall_cnt, last_tog, first_rise, first_fall, ur_last, ur_int;
  int ur_cnt0 = 0, ur_cnt2 = 0, ur3_cnt = 0, fall3 = 0, accepted = 0;
  int stab_viol = 0, clk_viol = 0, rdy_viol = 0, clk3_viol = 0;
  logic p_sclk0, p_sd0, p_lr0, p_sclk1, p_sd1, p_lr1, p_sclk3, rdy_prev, rdy3_prev;
  logic [63:0] sr0, sr1, sr2, lsr0, lsr1;
  logic [31:0] sr3, snap3;
  logic [15:0] src_l [0:7];
  logic [15:0] src_r [0:7];
  int src_n, src_idx, ur_base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One mclk cycle: sample at the falling edge, update the monitors, then drive the sources.
  task automatic step();
    logic fall0, fall1;
    @(negedge mclk);
    if (rst_n) begin
      cyc++;
      fall0 = p_sclk0 && !sclk0;
      fall1 = p_sclk1 && !sclk1;
      if (sclk0 != p_sclk0) begin
        if (cyc - last_tog != 4) clk_viol++;
        if (first_rise == 0) first_rise = cyc;
        last_tog = cyc;
      end
      if (fall0) begin
        fall_cnt++;
        if (first_fall == 0) first_fall = cyc;
        sr0  = {sr0[62:0], sd0};
        sr2  = {sr2[62:0], sd2};
        lsr0 = {lsr0[62:0], lr0};
      end else if (sd0 != p_sd0 || lr0 != p_lr0 || ur0 || ur2) begin
        stab_viol++;
      end
      if (fall1) begin
        sr1  = {sr1[62:0], sd1};
        lsr1 = {lsr1[62:0], lr1};
      end else if (sd1 != p_sd1 || lr1 != p_lr1 || ur1) begin
        stab_viol++;
      end
      if (ur0) begin
        ur_cnt0++;
        ur_int  = cyc - ur_last;
        ur_last = cyc;
      end
      if (ur2) ur_cnt2++;
      p_sclk0 = sclk0; p_sd0 = sd0; p_lr0 = lr0;
      p_sclk1 = sclk1; p_sd1 = sd1; p_lr1 = lr1;

      if (sclk3 == p_sclk3) clk3_viol++;
      if (p_sclk3 && !sclk3) begin
        fall3++;
        sr3 = {sr3[30:0], sd3};
        if (fall3 == 32) snap3 = sr3;
      end
      if (ur3) ur3_cnt++;
      p_sclk3 = sclk3;
      if (s_valid3 && rdy3_prev) s_valid3 = 1'b0;
      rdy3_prev = rdy3;

      if (s_valid && rdy_prev) begin
        accepted++;
        src_idx++;
        if (rdy0 !== 1'b0) rdy_viol++;
      end
      if (src_idx < src_n) begin
        s_valid = 1'b1;
        s_left  = src_l[src_idx];
        s_right = src_r[src_idx];
      end else begin
        s_valid = 1'b0;
      end
      rdy_prev = rdy0;
    end
  endtask

  task automatic run_falls(input int n, input string tag);
    int target, budget;
    target = fall_cnt + n;
    budget = n * 8 + 32;
    while (fall_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_falls"}, 64'(fall_cnt), 64'(target));
  endtask

  task automatic apply_reset(input int n);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    src_n   = 0;
    src_idx = 0;
    repeat (n) @(negedge mclk);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    cyc = 0; fall_cnt = 0; last_tog = 0; first_rise = 0; first_fall = 0; ur_last = 0;
    p_sclk0 = 1'b0; p_sd0 = 1'b0; p_lr0 = 1'b0;
    p_sclk1 = 1'b0; p_sd1 = 1'b0; p_lr1 = 1'b1;
    p_sclk3 = 1'b0; rdy_prev = 1'b1; rdy3_prev = 1'b1;
  endtask

  // {sclk, lrclk, sdata, s_ready, underrun}: only lrclk of the left-justified instance resets to 1.
  task automatic check_reset(input string tag);
    check({tag, "_dut0"}, 64'({sclk0, lr0, sd0, rdy0, ur0}), 64'(5'b00010));
    check({tag, "_dut1"}, 64'({sclk1, lr1, sd1, rdy1, ur1}), 64'(5'b01010));
    check({tag, "_dut2"}, 64'({sclk2, lr2, sd2, rdy2, ur2}), 64'(5'b00010));
    check({tag, "_dut3"}, 64'({sclk3, lr3, sd3, rdy3, ur3}), 64'(5'b00010));
  endtask

  task automatic push(input int i, input logic [15:0] l, input logic [15:0] r);
    src_l[i] = l;
    src_r[i] = r;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    s_valid3 = 1'b0; l3 = '0; r3 = '0;
    src_n = 0; src_idx = 0;
    sr0 = '0; sr1 = '0; sr2 = '0; lsr0 = '0; lsr1 = '0; sr3 = '0; snap3 = '0;

    // Power-up reset
    apply_reset(3);
    check_reset("rst0");
    check("mclk_o", 64'({mo0, mo1, mo2, mo3}), 64'({4{mclk}}));

    // Idle frames: clocking, word select, underrun cadence
    release_reset();
    l3 = 8'hC3; r3 = 8'h5A; s_valid3 = 1'b1;
    run_falls(64, "f1");
    check("first_rise", 64'(first_rise), 64'd4);
    check("first_fall", 64'(first_fall), 64'd8);
    check("f1_sdata", sr0, 64'h0);
    check("f1_lr_i2s", lsr0, 64'h0000_0001_FFFF_FFFE);
    check("f1_lr_lj", lsr1, 64'h0000_0000_FFFF_FFFF);
    check("f1_underrun", 64'(ur_cnt0), 64'd1);
    check("div1_frame", 64'(snap3), 64'hC300_5A00);
    check("div1_underruns", 64'(ur3_cnt), 64'd7);

    run_falls(64, "f2");
    check("f2_underrun", 64'(ur_cnt0), 64'd2);
    check("f2_ur_interval", 64'(ur_int), 64'd512);
    check("f2_sdata", sr0, 64'h0);

    // Streamed pairs with s_valid held high
    push(0, 16'h8001, 16'h00FF);
    push(1, 16'h0F0F, 16'hF0F0);
    push(2, 16'hFFFF, 16'h0001);
    push(3, 16'h7FFF, 16'h8000);
    src_idx = 0; src_n = 4;
    run_falls(64, "f3");
    check("f3_dut0", sr0, 64'h8001_0000_00FF_0000);
    check("f3_dut1", sr1, 64'h8001_0000_00FF_0000);
    check("f3_dut2", sr2, 64'h8001_0000_00FF_0000);
    check("f3_accepted", 64'(accepted), 64'd2);
    run_falls(64, "f4");
    check("f4_dut0", sr0, 64'h0F0F_0000_F0F0_0000);
    check("f4_accepted", 64'(accepted), 64'd3);
    run_falls(64, "f5");
    check("f5_dut0", sr0, 64'hFFFF_0000_0001_0000);
    check("f5_accepted", 64'(accepted), 64'd4);
    run_falls(64, "f6");
    check("f6_dut0", sr0, 64'h7FFF_0000_8000_0000);
    check("f6_accepted", 64'(accepted), 64'd4);
    check("stream_underrun", 64'(ur_cnt0), 64'd2);

    // Input stopped: repeat last pair, or zeros on the zero-fill instance
    run_falls(64, "f7");
    check("f7_repeat", sr0, 64'h7FFF_0000_8000_0000);
    check("f7_zero", sr2, 64'h0);
    check("f7_underrun0", 64'(ur_cnt0), 64'd3);
    check("f7_underrun2", 64'(ur_cnt2), 64'd3);

    // Reset in the middle of the right slot with a pair buffered
    run_falls(1, "f8_start");
    push(0, 16'h1111, 16'h2222);
    src_idx = 0; src_n = 1;
    run_falls(39, "f8_mid");
    check("mid_ready", 64'(rdy0), 64'd0);
    check("mid_lrclk", 64'({lr0, lr1}), 64'(2'b11));
    check("mid_accepted", 64'(accepted), 64'd5);
    apply_reset(1);
    check_reset("rst_mid");

    // Restart with a pair written before the first frame
    release_reset();
    push(0, 16'hA5F0, 16'h1234);
    src_idx = 0; src_n = 1;
    ur_base = ur_cnt0;
    run_falls(64, "r1");
    check("r1_first_rise", 64'(first_rise), 64'd4);
    check("r1_first_fall", 64'(first_fall), 64'd8);
    check("r1_dut0", sr0, 64'hA5F0_0000_1234_0000);
    check("r1_dut1", sr1, 64'hA5F0_0000_1234_0000);
    check("r1_dut2", sr2, 64'hA5F0_0000_1234_0000);
    check("r1_lr_i2s", lsr0, 64'h0000_0001_FFFF_FFFE);
    check("r1_lr_lj", lsr1, 64'h0000_0000_FFFF_FFFF);
    check("r1_no_underrun", 64'(ur_cnt0 - ur_base), 64'd0);
    run_falls(64, "r2");
    check("r2_repeat", sr0, 64'hA5F0_0000_1234_0000);
    check("r2_zero", sr2, 64'h0);
    check("r2_underrun", 64'(ur_cnt0 - ur_base), 64'd1);

    check("stable_between_ticks", 64'(stab_viol), 64'd0);
    check("sclk_half_period", 64'(clk_viol), 64'd0);
    check("ready_drop_after_write", 64'(rdy_viol), 64'd0);
    check("div1_sclk_toggle", 64'(clk3_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_tx_param.md
# i2s_tx_param

Parametrised I2S/left-justified stereo transmitter for the DDS audio path. Accepts stereo sample pairs from the DDS/sample source over a valid/ready handshake into a one-deep holding buffer. Generates SCLK and LRCLK from MCLK and shifts each channel out MSB-first in a configurable slot. Holding-buffer underrun is handled deterministically and flagged.

## Interface

Parameters:
- DATA_W, 16: sample width per channel; legal range 8..32, must be ≤ SLOT_W.
- SLOT_W, 32: SCLK periods per channel slot; 16..32. A frame is 2*SLOT_W SCLK periods.
- SCLK_DIV, 4: SCLK half-period in MCLK cycles; ≥ 1. SCLK = MCLK / (2*SCLK_DIV).
- MODE, 0: 0 = Philips I2S (MSB one SCLK after LRCLK edge); 1 = left-justified (MSB on LRCLK edge).
- UNDERRUN_ZERO, 0: 0 = repeat last sample pair on underrun; 1 = send zeros.

Ports:
- mclk, in, 1: sole clock. All logic is on its rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- s_valid, in, 1: sample pair valid.
- s_ready, out, 1: holding buffer empty; transfer occurs when s_valid && s_ready.
- s_left, in, DATA_W: left sample, two's complement.
- s_right, in, DATA_W: right sample.
- sclk_o, out, 1: bit clock, registered.
- lrclk_o, out, 1: word select; 0 = left, 1 = right, registered.
- sdata_o, out, 1: serial data, registered.
- mclk_o, out, 1: mclk passthrough.
- underrun_o, out, 1: one-mclk pulse when a frame starts with the holding buffer empty.

## Operation

Clock generation:
- div_cnt runs 0..SCLK_DIV-1 and wraps.
- sclk_o toggles on each wrap.
- "Fall tick" is the mclk cycle in which sclk_o is updated from 1 to 0. All sdata_o and lrclk_o updates occur on fall ticks only.

Slot position:
- pos runs 0..2*SLOT_W-1 and advances by 1 on each fall tick, wrapping to 0.
- pos = 0 is the frame start.
- Channel is pos / SLOT_W (0 = left). Bit index b = pos mod SLOT_W.

Data output:
- sdata_o = sample[DATA_W-1-b] when b < DATA_W, else 0.
- sample is left_sh for channel 0 and right_sh for channel 1.

Word select:
- MODE 1: lrclk_o = (pos ≥ SLOT_W).
- MODE 0: lrclk_o = (((pos+1) mod 2*SLOT_W) ≥ SLOT_W). LRCLK therefore leads the data by one bit.

Holding buffer:
- One entry plus a full flag.
- Write occurs when s_valid && s_ready. s_ready = !full.

Frame load, on the fall tick entering pos 0:
- If full: left_sh/right_sh ← holding contents and full is cleared.
- If empty: left_sh/right_sh keep their previous values (UNDERRUN_ZERO=0) or load 0 (UNDERRUN_ZERO=1), and underrun_o pulses for that one cycle.
- If a write and an empty-buffer load fall in the same cycle, the write fills the holding buffer for the next frame. It is not used in the current frame.
- When full, s_ready=0, so write and load never conflict.

Reset, while rst_n=0 at a rising mclk edge:
- div_cnt=0, sclk_o=0, pos=2*SLOT_W-1.
- lrclk_o = 0 in MODE 0, 1 in MODE 1.
- sdata_o=0, full=0 (s_ready=1), left_sh=right_sh=0, underrun_o=0.
- Reset mid-frame aborts the frame immediately. Any buffered sample is discarded.

## Timing

- First sclk_o rise occurs SCLK_DIV mclk cycles after the first cycle with rst_n=1. The first fall tick, at 2*SCLK_DIV cycles, is frame start.
- sdata_o and lrclk_o change only on the fall tick, i.e. in the same cycle sclk_o goes low. They are stable for the whole high phase.
- Input to wire latency: a pair accepted before a frame-start tick is shifted out in that frame. Its left MSB appears on sdata_o at that tick. In MODE 0 this is one SCLK after LRCLK fell.
- s_ready deasserts the cycle after a write. It reasserts the cycle after the frame-start load.
- Sustained throughput: one pair per 4*SLOT_W*SCLK_DIV mclk cycles.
- SCLK_DIV=1: sclk_o toggles every cycle and every second cycle is a fall tick. This case must work.

## Test plan

Defaults for all scenarios unless stated: DATA_W=16, SLOT_W=32, SCLK_DIV=4, MODE 0.

1. Reset, then idle with s_valid=0 → sclk_o period 8 mclk. underrun_o pulses once per 512 mclk cycles. sdata_o stays 0. lrclk_o falls one SCLK before each frame start.
2. Write L=0xA5F0, R=0x1234 before the first frame → left slot bits are 1010010111110000 followed by 16 zeros. Right slot carries 0x1234 MSB-first. No underrun_o pulse on that frame.
3. MODE 1 with the same data → the MSB of 0xA5F0 is on the same fall tick as lrclk_o falling. The MSB of 0x1234 (0) is on lrclk_o rising.
4. Stream 4 pairs with s_valid held high → s_ready accepts exactly one pair per frame. Output order matches input order. underrun_o never pulses.
5. Stop input after 0x7FFF/0x8000 → the next frame repeats 0x7FFF/0x8000 with underrun_o pulsing. With UNDERRUN_ZERO=1 the frame is all zeros instead.
6. Assert rst_n=0 mid-right-slot with the buffer full → the next cycle shows all outputs at reset values and s_ready=1. Restart timing matches scenario 1.
